ptw_arbiter: RTL
================

// Module: ptw_arbiter
// PURPOSE
//  Shares the single page-table walk unit between the I-side and D-side TLB miss paths.
//  Accepts one outstanding miss per side and picks the next side round-robin.
//  Issues a one-cycle walk request, waits for walker finish and returns the leaf PTE to the winner.
//  Sits between the ITLB/DTLB miss ports and the walker. The walker's cache port is not touched here.
// PARAMETERS
//  ADDR_WIDTH  64  width of VA, PPN base and PTE buses
// PORTS
//  clk            in   1           clock; all state on posedge
//  rst            in   1           asynchronous, active-high reset
//  i_req          in   1           I-side miss pending; held high with i_va stable until i_done
//  i_va           in   ADDR_WIDTH  I-side virtual address
//  i_done         out  1           one-cycle pulse: i_pte valid
//  i_pte          out  ADDR_WIDTH  PTE returned to I-side
//  d_req          in   1           D-side miss pending; same rules as i_req
//  d_va           in   ADDR_WIDTH  D-side virtual address
//  d_done         out  1           one-cycle pulse: d_pte valid
//  d_pte          out  ADDR_WIDTH  PTE returned to D-side
//  satp_ppn       in   ADDR_WIDTH  root page-table PPN, sampled at grant
//  walk_req       out  1           one-cycle request pulse to walker
//  walk_va        out  ADDR_WIDTH  latched VA of granted side; stable from ISSUE through RESP
//  walk_ppn_base  out  ADDR_WIDTH  latched satp_ppn
//  walk_pte       in   ADDR_WIDTH  walker result, valid while walk_finish=1
//  walk_finish    in   1           walker completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; i_done=d_done=walk_req=0; i_pte=d_pte=walk_va=walk_ppn_base=0; last_grant=D.
//   With last_grant=D, I-side wins the first tie.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - No requests: stay in IDLE.
//   - Any request pending: pick the winner and latch its va, satp_ppn and grant id.
//   - Next state ISSUE.
//  Arbitration: only one side pending -> that side wins; both pending -> the side != last_grant wins.
//   last_grant updates at the grant.
//  ISSUE: walk_req=1 for exactly this cycle; then WAIT.
//  WAIT
//   - walk_req=0. Stay until walk_finish=1.
//   - On walk_finish, latch walk_pte into the winner's pte register and go to RESP.
//   - walk_finish in ISSUE or IDLE is ignored.
//  RESP: winner's done=1 for one cycle, pte held; then IDLE.
//   - The loser's done stays 0.
//   - {i,d}_pte holds its value until overwritten by the next walk for that side.
//  Latency: req high in cycle N (state IDLE) -> walk_req in N+1; walk_finish in cycle F -> done in F+1.
//   Minimum total is 3 cycles plus walker time.
//  Requester rule: req must be low in the cycle after done, unless a new miss is pending.
//   A req high in the cycle after RESP is treated as a new request.
//  Simultaneous events: a new req arriving while busy waits; it is not dropped.
//   Requests are level-sensitive, so nothing is queued beyond one per side.
//  PTE contents (valid, fault, superpage) are not interpreted; faults pass through unchanged.
//  Reset mid-walk: returns to IDLE immediately and no done is produced.
//   The walker must be reset by the same reset; top ties the walker's active-low reset to ~rst.
// CONFIGURATION
//  Macro PTW_ARB_FLUSH_EN adds port: flush  in  1  sfence/satp-write flush.
//   - flush in ISSUE or WAIT sets drop flag; the walk runs to walk_finish (walker is not abortable).
//   - A dropped walk goes to IDLE from WAIT, skips RESP, and asserts no done; pte registers keep their old values.
//   - flush in RESP: done is still asserted (already committed).
//   - flush in IDLE: no effect.
//   - The drop flag clears on entering IDLE.
//  Without the macro there is no flush port, and every granted walk produces exactly one done.
// STRUCTURE
//  Package PageStruct gains:
//   - typedef enum ptw_arb_state_t {IDLE, ISSUE, WAIT, RESP}
//   - typedef logic ptw_src_t, with constants SRC_I=0, SRC_D=1
//  Sub-module rr_pick2, combinational:
//   - inputs (req_i, req_d, last)
//   - outputs (gnt_valid, gnt_src)
//  Reused by later two-requester arbiters.
// TESTING
//  1. i_req=1, i_va=0x0000_0040_1234_5000; walker finishes 5 cycles after walk_req, pte=0x2000_04CF
//     -> walk_req 1 cycle after i_req; i_done 1 cycle after finish with i_pte=0x2000_04CF; d_done=0 throughout.
//  2. i_req and d_req both rise in the same cycle after reset
//     -> I served first, then D.
//     -> walk_va equals i_va for the first walk and d_va for the second; exactly two walk_req pulses.
//  3. Both requesters re-raise req after every done, 6 walks total
//     -> grant order I, D, I, D, I, D; no side is granted twice in a row while the other is pending.
//  4. d_req raised while an I walk is in WAIT
//     -> D is granted in the IDLE cycle after i_done; d_va is latched then, not earlier.
//  5. rst pulsed for 1 cycle during WAIT
//     -> all outputs 0 next cycle; no done; a subsequent i_req completes normally.
//  6. (PTW_ARB_FLUSH_EN) flush=1 for 1 cycle during WAIT of a D walk
//     -> walk finishes, d_done never asserts, d_pte unchanged; the next pending I request is granted.

Source files
------------

// File: rtl/ptw_arbiter_pkg.sv
// Shared types for the page-table-walk arbiter and its round-robin picker.
// State encoding, requester id type and a small helper for alternating grants.
// Consumers import ptw_arbiter_pkg::*.
package ptw_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ptw_arb_state_t;

  typedef logic ptw_src_t;

  localparam ptw_src_t SRC_I = 1'b0;
  localparam ptw_src_t SRC_D = 1'b1;

  // The requester that did not win last time.
  function automatic ptw_src_t other_src(input ptw_src_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/ptw_arbiter_rr_pick2.sv
// Two-requester round-robin picker, purely combinational.
// Single pending side wins outright; on a tie the side that did not win last time is picked.
// No state here: the caller owns and updates 'last' at the grant.
module rr_pick2
  import ptw_arbiter_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  ptw_src_t last,
  output logic     gnt_valid,
  output ptw_src_t gnt_src
);

  // Tie-break toward the side that was not granted last.
  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_src = other_src(last);
    end else if (req_d) begin
      gnt_src = SRC_D;
    end else begin
      gnt_src = SRC_I;
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the I-side and D-side TLB miss ports, round-robin.
// Latency: req in IDLE cycle N -> walk_req in N+1; walk_finish in cycle F -> done in F+1.
// One outstanding miss per side; a request arriving while busy stays pending (level-sensitive).
// Optional macro PTW_ARB_FLUSH_EN adds a flush input that drops the in-flight walk's response.
module ptw_arbiter
  import ptw_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PTW_ARB_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_va,
  output logic                  i_done,
  output logic [ADDR_WIDTH-1:0] i_pte,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_va,
  output logic                  d_done,
  output logic [ADDR_WIDTH-1:0] d_pte,
  input  logic [ADDR_WIDTH-1:0] satp_ppn,
  output logic                  walk_req,
  output logic [ADDR_WIDTH-1:0] walk_va,
  output logic [ADDR_WIDTH-1:0] walk_ppn_base,
  input  logic [ADDR_WIDTH-1:0] walk_pte,
  input  logic                  walk_finish
);

  ptw_arb_state_t        state_q, state_d;
  ptw_src_t              last_q, last_d;
  ptw_src_t              src_q, src_d;
  logic [ADDR_WIDTH-1:0] va_q, va_d;
  logic [ADDR_WIDTH-1:0] ppn_q, ppn_d;
  logic [ADDR_WIDTH-1:0] i_pte_q, i_pte_d;
  logic [ADDR_WIDTH-1:0] d_pte_q, d_pte_d;
  logic                  gnt_valid;
  ptw_src_t              gnt_src;
  logic                  drop_now;

`ifdef PTW_ARB_FLUSH_EN
  logic drop_q, drop_d;

  // A flush seen in ISSUE/WAIT (including the finish cycle itself) discards this walk's result.
  always_comb begin
    drop_now = drop_q | flush;
  end
`else
  // Without flush support every granted walk is answered.
  always_comb begin
    drop_now = 1'b0;
  end
`endif

  rr_pick2 u_pick (
    .req_i     (i_req),
    .req_d     (d_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_src   (gnt_src)
  );

  // Next-state: grant in IDLE, one-cycle issue, wait for walker, one-cycle response.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    va_d    = va_q;
    ppn_d   = ppn_q;
    i_pte_d = i_pte_q;
    d_pte_d = d_pte_q;
`ifdef PTW_ARB_FLUSH_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef PTW_ARB_FLUSH_EN
        drop_d = 1'b0;
`endif
        if (gnt_valid) begin
          state_d = ISSUE;
          src_d   = gnt_src;
          last_d  = gnt_src;
          va_d    = (gnt_src == SRC_D) ? d_va : i_va;
          ppn_d   = satp_ppn;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef PTW_ARB_FLUSH_EN
        drop_d  = drop_now;
`endif
      end
      WAIT: begin
`ifdef PTW_ARB_FLUSH_EN
        drop_d = drop_now;
`endif
        if (walk_finish) begin
          if (drop_now) begin
            // Walker could not be aborted; its result is simply discarded.
            state_d = IDLE;
`ifdef PTW_ARB_FLUSH_EN
            drop_d  = 1'b0;
`endif
          end else begin
            state_d = RESP;
            if (src_q == SRC_D) begin
              d_pte_d = walk_pte;
            end else begin
              i_pte_d = walk_pte;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef PTW_ARB_FLUSH_EN
        drop_d  = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also abandons any walk in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SRC_D;
      src_q   <= SRC_I;
      va_q    <= '0;
      ppn_q   <= '0;
      i_pte_q <= '0;
      d_pte_q <= '0;
`ifdef PTW_ARB_FLUSH_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      va_q    <= va_d;
      ppn_q   <= ppn_d;
      i_pte_q <= i_pte_d;
      d_pte_q <= d_pte_d;
`ifdef PTW_ARB_FLUSH_EN
      drop_q  <= drop_d;
`endif
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    walk_req      = (state_q == ISSUE);
    walk_va       = va_q;
    walk_ppn_base = ppn_q;
    i_done        = (state_q == RESP) && (src_q == SRC_I);
    d_done        = (state_q == RESP) && (src_q == SRC_D);
    i_pte         = i_pte_q;
    d_pte         = d_pte_q;
  end

endmodule
